sync_fifo_gen2: RTL and testbench
=================================

Name: sync_fifo_gen2

Overview:
- Parametrised successor to the team's single-clock FIFO.
- Supports any depth, including non-power-of-2, and programmable almost-full/almost-empty thresholds.
- Offers selectable standard or first-word-fall-through (FWFT) read mode, and write pass-through when full if a read occurs in the same cycle.
- Exposes occupancy count and a read-valid strobe; sits between producer and consumer datapaths in the same clock domain.

Parameters:
- FIFO_WIDTH, 16, data width in bits.
- FIFO_DEPTH, 8, number of entries; any value >= 2.
- AFULL_TH, FIFO_DEPTH-1, almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write request.
- data_in  in  FIFO_WIDTH  write data.
- rd_en  in  1  read request (acknowledge in FWFT mode).
- data_out  out  FIFO_WIDTH  read data.
- rd_valid  out  1  data_out holds a newly read word.
- wr_ack  out  1  previous-cycle write accepted.
- overflow  out  1  previous-cycle write rejected.
- underflow  out  1  previous-cycle read rejected.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  CW = $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset: clk rising edge with rst=1. Result: count=0, wr_ptr=rd_ptr=0, data_out=0, rd_valid=0, wr_ack=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_TH>0).
  - Memory contents are not cleared.
  - Reset mid-burst discards all stored data; the next cycle behaves as post-reset.
  - rst has priority over wr_en/rd_en.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_acc). A write while full with a simultaneous accepted read is accepted.
  - Write while empty with rd_en: write accepted, read rejected (underflow=1). No bypass.
- Count update:
  - +1 if wr_acc && !rd_acc.
  - -1 if rd_acc && !wr_acc.
  - Otherwise unchanged.
  - count never exceeds FIFO_DEPTH and never goes below 0.
- Pointers: each pointer is $clog2(FIFO_DEPTH) bits, increments on its accept, and wraps from FIFO_DEPTH-1 to 0 explicitly (no power-of-2 rollover).
- Response flags, all registered and valid in the cycle after the request:
  - wr_ack = wr_acc.
  - overflow = wr_en && !wr_acc.
  - underflow = rd_en && !rd_acc.
  - Each flag is a 1-cycle pulse per request.
- Status flags: combinational from count; they update in the same cycle count changes.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr] and rd_valid=1 on the next cycle. Otherwise rd_valid=0 and data_out holds its last value.
- FWFT=1: data_out = mem[rd_ptr] combinationally whenever !empty. rd_valid = !empty; rd_en pops the head. data_out is don't-care while empty.
- Ordering: strict FIFO; data words leave in write order across pointer wrap.
- Written data is visible to a read no earlier than the cycle after the write.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined:
  - Adds input err_clr (1 bit) and outputs ovf_sticky and udf_sticky (1 bit each).
  - Each sticky bit is set on the cycle its pulse flag asserts and held until err_clr=1 or rst.
  - Set takes priority over clear in the same cycle.
  - Reset value 0.
- Not defined: ports absent; overflow/underflow remain pulse-only.

Test Plan:
- Reset then idle, FIFO_DEPTH=6, FIFO_WIDTH=8 -> empty=1, almost_empty=1, count=0, data_out=0, all pulse flags 0.
- Write 0x01..0x06 back-to-back, then wr_en once more -> wr_ack=1 for six cycles, full=1 and count=6 after the 6th, overflow=1 for one cycle on the 7th, almost_full=1 from count=5.
- From full (0x01..0x06), wr_en=rd_en=1 with data 0x07 -> read returns 0x01, wr_ack=1, count stays 6. Draining 6 words gives 0x02..0x07 across the pointer wrap.
- Empty FIFO, wr_en=rd_en=1 with 0xAA -> wr_ack=1, underflow=1, count=1. The next read returns 0xAA (FWFT=0: rd_valid and data_out=0xAA one cycle after rd_en).
- FWFT=1, write 0x55 -> next cycle data_out=0x55 and rd_valid=1 without rd_en. rd_en pop -> empty=1 and rd_valid=0.
- FIFO_STICKY_ERR_EN defined: rd_en on empty -> udf_sticky=1 held for 10 idle cycles. err_clr pulse -> 0. rst asserted mid-burst with count=3 -> count=0 next cycle.

Source files
------------

// File: rtl/sync_fifo_gen2_if.sv
// Producer/consumer bus for sync_fifo_gen2.
// With FIFO_STICKY_ERR_EN defined the bus also carries err_clr and the
// ovf_sticky/udf_sticky error latches.
interface sync_fifo_gen2_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int CW         = 4
);
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
`ifdef FIFO_STICKY_ERR_EN
  logic                  err_clr;
  logic                  ovf_sticky;
  logic                  udf_sticky;

  // Producer/consumer side
  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almost_full, almost_empty, count,
           ovf_sticky, udf_sticky
  );

  // FIFO side
  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almost_full, almost_empty, count,
           ovf_sticky, udf_sticky
  );
`else
  // Producer/consumer side
  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almost_full, almost_empty, count
  );

  // FIFO side
  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almost_full, almost_empty, count
  );
`endif
endinterface

// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO, any depth >= 2, standard or first-word-fall-through read.
// A write while full is accepted when a read is accepted in the same cycle.
// Optional macro FIFO_STICKY_ERR_EN adds sticky overflow/underflow latches
// cleared by err_clr.
module sync_fifo_gen2 #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_TH   = FIFO_DEPTH - 1,
  parameter int AEMPTY_TH  = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_gen2_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  empty_c, full_c;
  logic                  rd_acc, wr_acc;
  logic                  ovf_n, udf_n;

  // Accept decisions use pre-edge occupancy only; no empty bypass.
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == DEPTH_C);
  assign rd_acc  = bus.rd_en && !empty_c;
  assign wr_acc  = bus.wr_en && (!full_c || rd_acc);
  assign ovf_n   = bus.wr_en && !wr_acc;
  assign udf_n   = bus.rd_en && !rd_acc;

  // Pointers wrap explicitly at FIFO_DEPTH-1 so odd depths work; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  // One-cycle response pulses for the previous cycle's requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.wr_ack    <= wr_acc;
      bus.overflow  <= ovf_n;
      bus.underflow <= udf_n;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented as soon as it exists; rd_en acknowledges it.
      assign bus.data_out = empty_c ? '0 : mem[rd_ptr];
      assign bus.rd_valid = !empty_c;
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;
      logic                  rv_q;
      // Registered read: word and strobe appear the cycle after the accepted read.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          rv_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr];
        end
      end
      assign bus.data_out = dout_q;
      assign bus.rd_valid = rv_q;
    end
  endgenerate

  // Status flags follow count in the same cycle.
  assign bus.count        = count_q;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);

`ifdef FIFO_STICKY_ERR_EN
  // Sticky error latches: set together with the pulse, set wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ovf_sticky <= 1'b0;
      bus.udf_sticky <= 1'b0;
    end else begin
      bus.ovf_sticky <= ovf_n || (bus.ovf_sticky && !bus.err_clr);
      bus.udf_sticky <= udf_n || (bus.udf_sticky && !bus.err_clr);
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Bench for sync_fifo_gen2: a standard-read and an FWFT instance (depth 6,
// width 8) share one stimulus stream and one queue-based reference model.
module tb_sync_fifo_gen2;
  localparam int W  = 8;
  localparam int D  = 6;
  localparam int CW = 3;
  localparam int AF = D - 1;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en, rd_en;
  logic [W-1:0] data_in;
`ifdef FIFO_STICKY_ERR_EN
  logic         err_clr;
`endif

  sync_fifo_gen2_if #(.FIFO_WIDTH(W), .CW(CW)) bus0 ();
  sync_fifo_gen2_if #(.FIFO_WIDTH(W), .CW(CW)) bus1 ();

  assign bus0.wr_en   = wr_en;
  assign bus0.rd_en   = rd_en;
  assign bus0.data_in = data_in;
  assign bus1.wr_en   = wr_en;
  assign bus1.rd_en   = rd_en;
  assign bus1.data_in = data_in;
`ifdef FIFO_STICKY_ERR_EN
  assign bus0.err_clr = err_clr;
  assign bus1.err_clr = err_clr;
`endif

  sync_fifo_gen2 #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b0))
    u_std (.clk(clk), .rst(rst), .bus(bus0));
  sync_fifo_gen2 #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b1))
    u_fwft (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of stored words plus the registered responses.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  bit m_rv, m_ack, m_ovf, m_udf;
`ifdef FIFO_STICKY_ERR_EN
  bit m_ost, m_ust;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit w, input bit rd, input logic [W-1:0] d, input bit c);
    bit ra, wa;
    if (r) begin
      q.delete();
      m_dout = '0; m_rv = 0; m_ack = 0; m_ovf = 0; m_udf = 0;
`ifdef FIFO_STICKY_ERR_EN
      m_ost = 0; m_ust = 0;
`endif
    end else begin
      ra = rd && (q.size() > 0);
      wa = w && ((q.size() < D) || ra);
      m_rv = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      m_ack = wa;
      m_ovf = w && !wa;
      m_udf = rd && !ra;
`ifdef FIFO_STICKY_ERR_EN
      m_ost = m_ovf || (m_ost && !c);
      m_ust = m_udf || (m_ust && !c);
`endif
    end
  endtask

  task automatic cmp_status(input string t, input logic ack, input logic ovf, input logic udf,
                            input logic fu, input logic em, input logic af, input logic ae,
                            input logic [CW-1:0] cnt);
    int n = q.size();
    chk({t, "_ack"}, 32'(ack), 32'(m_ack));
    chk({t, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({t, "_udf"}, 32'(udf), 32'(m_udf));
    chk({t, "_cnt"}, 32'(cnt), 32'(n));
    chk({t, "_full"}, 32'(fu), 32'(n == D));
    chk({t, "_empty"}, 32'(em), 32'(n == 0));
    chk({t, "_afull"}, 32'(af), 32'(n >= AF));
    chk({t, "_aempty"}, 32'(ae), 32'(n <= AE));
  endtask

  task automatic cmp_model();
    cmp_status("std", bus0.wr_ack, bus0.overflow, bus0.underflow, bus0.full, bus0.empty,
               bus0.almost_full, bus0.almost_empty, bus0.count);
    cmp_status("fwft", bus1.wr_ack, bus1.overflow, bus1.underflow, bus1.full, bus1.empty,
               bus1.almost_full, bus1.almost_empty, bus1.count);
    chk("std_rv", 32'(bus0.rd_valid), 32'(m_rv));
    chk("std_dout", 32'(bus0.data_out), 32'(m_dout));
    chk("fwft_rv", 32'(bus1.rd_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("fwft_dout", 32'(bus1.data_out), 32'(q[0]));
`ifdef FIFO_STICKY_ERR_EN
    chk("std_ost", 32'(bus0.ovf_sticky), 32'(m_ost));
    chk("std_ust", 32'(bus0.udf_sticky), 32'(m_ust));
    chk("fwft_ost", 32'(bus1.ovf_sticky), 32'(m_ost));
    chk("fwft_ust", 32'(bus1.udf_sticky), 32'(m_ust));
`endif
  endtask

  // One clock: capture inputs, advance model at the edge, compare 1ns later.
  task automatic step();
    bit r = rst, w = wr_en, rd = rd_en, c = 1'b0;
    logic [W-1:0] d = data_in;
`ifdef FIFO_STICKY_ERR_EN
    c = err_clr;
`endif
    @(posedge clk);
    model_update(r, w, rd, d, c);
    #1;
    cmp_model();
  endtask

  task automatic drive(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
    rst = r; wr_en = w; rd_en = rd; data_in = d;
  endtask

  typedef struct {
    bit           rst, wr, rd;
    logic [W-1:0] din;
    bit           ack, ovf, udf, rv;
    logic [W-1:0] dout;
    int           cnt;
  } vec_t;
  vec_t vt[$];

  function automatic void add(bit r, bit w, bit rd, logic [W-1:0] din,
                              bit ack, bit ovf, bit udf, bit rv, logic [W-1:0] dout, int cnt);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.din = din;
    v.ack = ack; v.ovf = ovf; v.udf = udf; v.rv = rv; v.dout = dout; v.cnt = cnt;
    vt.push_back(v);
  endfunction

  initial begin
    drive(1, 0, 0, '0);
`ifdef FIFO_STICKY_ERR_EN
    err_clr = 1'b0;
`endif

    // Directed table for the standard-read instance.
    //   rst wr rd din    ack ovf udf rv dout  cnt
    add(1, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00, 0);
    for (int k = 1; k <= 6; k++) add(0, 1, 0, 8'(k), 1, 0, 0, 0, 8'h00, k);
    add(0, 1, 0, 8'h77,  0, 1, 0, 0, 8'h00, 6);   // write into full -> overflow
    add(0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00, 6);   // overflow was a single pulse
    add(0, 1, 1, 8'h07,  1, 0, 0, 1, 8'h01, 6);   // pass-through write while full
    for (int k = 2; k <= 7; k++) add(0, 0, 1, 8'h00, 0, 0, 0, 1, 8'(k), 7 - k);
    add(0, 0, 1, 8'h00,  0, 0, 1, 0, 8'h07, 0);   // read on empty, data_out holds
    add(0, 1, 1, 8'hAA,  1, 0, 1, 0, 8'h07, 1);   // no bypass on empty
    add(0, 0, 1, 8'h00,  0, 0, 0, 1, 8'hAA, 0);
    add(0, 0, 0, 8'h00,  0, 0, 0, 0, 8'hAA, 0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].wr, vt[i].rd, vt[i].din);
      step();
      chk($sformatf("v%0d_ack", i), 32'(bus0.wr_ack), 32'(vt[i].ack));
      chk($sformatf("v%0d_ovf", i), 32'(bus0.overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d_udf", i), 32'(bus0.underflow), 32'(vt[i].udf));
      chk($sformatf("v%0d_rv", i), 32'(bus0.rd_valid), 32'(vt[i].rv));
      chk($sformatf("v%0d_dout", i), 32'(bus0.data_out), 32'(vt[i].dout));
      chk($sformatf("v%0d_cnt", i), 32'(bus0.count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(bus0.empty), 32'(vt[i].cnt == 0));
      chk($sformatf("v%0d_full", i), 32'(bus0.full), 32'(vt[i].cnt == D));
      chk($sformatf("v%0d_af", i), 32'(bus0.almost_full), 32'(vt[i].cnt >= AF));
      chk($sformatf("v%0d_ae", i), 32'(bus0.almost_empty), 32'(vt[i].cnt <= AE));
    end

    // FWFT: head word shows up without rd_en, pop empties it.
    drive(1, 0, 0, '0); step();
    drive(0, 1, 0, 8'h55); step();
    drive(0, 0, 0, '0);
    chk("fwft_head", 32'(bus1.data_out), 32'h55);
    chk("fwft_head_rv", 32'(bus1.rd_valid), 32'd1);
    drive(0, 0, 1, '0); step();
    drive(0, 0, 0, '0);
    chk("fwft_pop_empty", 32'(bus1.empty), 32'd1);
    chk("fwft_pop_rv", 32'(bus1.rd_valid), 32'd0);

    // Reset mid-burst with count=3; rst wins over a concurrent write.
    for (int k = 0; k < 3; k++) begin drive(0, 1, 0, 8'hC0 + 8'(k)); step(); end
    chk("burst_cnt3", 32'(bus0.count), 32'd3);
    drive(1, 1, 0, 8'hEE); step();
    chk("rst_cnt", 32'(bus0.count), 32'd0);
    chk("rst_empty", 32'(bus0.empty), 32'd1);
    chk("rst_fwft_rv", 32'(bus1.rd_valid), 32'd0);
    drive(0, 1, 0, 8'h3C); step();
    drive(0, 0, 1, '0); step();
    drive(0, 0, 0, '0);
    chk("post_rst_word", 32'(bus0.data_out), 32'h3C);

`ifdef FIFO_STICKY_ERR_EN
    drive(0, 0, 1, '0); step();
    drive(0, 0, 0, '0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("udf_sticky_hold", 32'(bus0.udf_sticky), 32'd1);
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("udf_sticky_clr", 32'(bus0.udf_sticky), 32'd0);
    drive(0, 0, 1, '0); err_clr = 1'b1; step(); err_clr = 1'b0;
    drive(0, 0, 0, '0);
    chk("udf_set_beats_clr", 32'(bus0.udf_sticky), 32'd1);
`endif

    // Randomized traffic, phases biased toward filling, draining and mixed.
    for (int c = 0; c < 3000; c++) begin
      int ph = (c / 150) % 3;
      rst = ($urandom_range(0, 199) == 0);
      case (ph)
        0:       begin wr_en = ($urandom_range(0, 9) < 8); rd_en = ($urandom_range(0, 9) < 3); end
        1:       begin wr_en = ($urandom_range(0, 9) < 2); rd_en = ($urandom_range(0, 9) < 8); end
        default: begin wr_en = 1'($urandom_range(0, 1)); rd_en = 1'($urandom_range(0, 1)); end
      endcase
      data_in = 8'($urandom);
`ifdef FIFO_STICKY_ERR_EN
      err_clr = ($urandom_range(0, 19) == 0);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
